// File: rtl/rf_write_sched_pkg.sv
// Shared constants and state encoding for the register-file write scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package rf_write_sched_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rf_write_sched_arb.sv
// Two-way round-robin arbiter, purely combinational.
// pri selects the winner only when both requesters are valid.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       pri_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (1'b1)
      (valid_i == 2'b11): grant_o = pri_i ? 2'b10 : 2'b01;
      (valid_i == 2'b01): grant_o = 2'b01;
      (valid_i == 2'b10): grant_o = 2'b10;
      default:            grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: clears r1..r31 after reset, then
// shares the single write port between ALU and load writeback.
module rf_write_sched
  import rf_write_sched_pkg::*;
(
  input  logic              CLK,
  input  logic              clrn,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              init_done,
  output logic              WE,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rr_pri_q, rr_pri_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [1:0]        gnt;
  logic [1:0]        rdy;

  rr_arb2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .pri_i   (rr_pri_q),
    .grant_o (gnt)
  );

  // Grants are masked until the clear pass has finished.
  assign rdy        = (state_q == RUN) ? gnt : 2'b00;
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_pri_d  = rr_pri_q;
    we_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    unique case (state_q)
      INIT: begin
        we_d      = 1'b1;
        wreg_d    = clr_cnt_q;
        wdata_d   = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == REG_LAST) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        if (rdy[0]) begin
          wreg_d   = req0_reg;
          wdata_d  = req0_data;
          we_d     = (req0_reg != REG_ZERO);
          rr_pri_d = 1'b1;
        end else if (rdy[1]) begin
          wreg_d   = req1_reg;
          wdata_d  = req1_data;
          we_d     = (req1_reg != REG_ZERO);
          rr_pri_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      state_q   <= INIT;
      clr_cnt_q <= ADDR_W'(1);
      rr_pri_q  <= 1'b0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_pri_q  <= rr_pri_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
    end
  end

  assign WE        = we_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign init_done = done_q;

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
Write-port scheduler for the 32x32 register file. After reset it sequences a clear pass that writes zero to r1..r31. It then shares the single write port between two writeback requesters (req0 = ALU writeback, req1 = load writeback) using valid/ready handshakes and round-robin priority. It drives the regfile WE, WriteReg and WriteData inputs directly from registered outputs.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width
NUM_REGS, 32, register count; r0 is hardwired zero and never written

Ports:
CLK  input  1  clock, rising edge
clrn  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 has a write pending
req0_reg  input  ADDR_W  requester 0 destination index
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 has a write pending
req1_reg  input  ADDR_W  requester 1 destination index
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle
init_done  output  1  clear pass complete; scheduler accepting requests
WE  output  1  regfile write enable (registered)
WriteReg  output  ADDR_W  regfile write index (registered)
WriteData  output  DATA_W  regfile write data (registered)

Behaviour:
- Reset: asynchronous, active-low.
  - Resets: state=INIT, clr_cnt=1, rr_pri=0 (req0 favoured), WE=0, WriteReg=0, WriteData=0, init_done=0.
  - req0_ready=0 and req1_ready=0 while in INIT.
- State INIT: on each CLK edge: WE<=1, WriteReg<=clr_cnt, WriteData<=0, clr_cnt<=clr_cnt+1.
  - On the edge where clr_cnt==NUM_REGS-1: state<=RUN and init_done<=1, in the same edge as the r31 write.
  - The clear pass therefore takes exactly 31 edges. Requests are ignored and never acknowledged during INIT.
- State RUN: ready signals are combinational from valid inputs, state and rr_pri.
  - Only req0 valid -> req0_ready=1.
  - Only req1 valid -> req1_ready=1.
  - Both valid -> grant req[rr_pri] only.
  - Neither valid -> no ready asserted.
  - At most one ready is high per cycle; readyN never rises without validN.
- Transfer: occurs when valid&ready at a rising edge. On that edge:
  - WriteReg<=reqN_reg, WriteData<=reqN_data.
  - WE<=1 if reqN_reg!=0, else WE<=0. A write to r0 is acknowledged and silently dropped.
  - rr_pri<=~N.
- No transfer: WE<=0; WriteReg and WriteData hold their previous values.
- Latency: a request accepted on edge k appears on WE/WriteReg/WriteData from edge k until edge k+1. The regfile commits it on edge k+1.
- Throughput: one write per cycle, sustained.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1,...
- A lone requester never loses cycles: rr_pri only flips on a grant.
- Same destination from both requesters: serialised in grant order; the later grant wins in the register.
- Requester contract: valid must stay asserted with reg/data stable until ready. The scheduler may withdraw ready only when valid drops.
- Reset mid-INIT or mid-RUN: outputs clear immediately (asynchronous). Any in-flight registered write is dropped. The full clear pass restarts after clrn rises.
- RUN is terminal until the next reset; init_done never deasserts outside reset.

Decomposition:
- Shared package: constants DATA_W, ADDR_W, NUM_REGS, REG_ZERO=0; state encoding INIT=1'b0, RUN=1'b1.
- One natural sub-module: rr_arb2. It is a 2-way round-robin arbiter with inputs valid[1:0] and pri, and outputs grant[1:0]; it is purely combinational.
- The pri flop and the FSM stay in rf_write_sched.

Test Plan:
- Release clrn, no requests -> 31 cycles with WE=1, WriteReg=1..31, WriteData=0; init_done=1 coincident with WriteReg=31; then WE=0.
- During INIT, hold req0_valid=1, reg=5, data=0xDEAD_BEEF -> req0_ready=0 throughout INIT. First RUN cycle: req0_ready=1; next edge: WE=1, WriteReg=5, WriteData=0xDEADBEEF.
- In RUN, both valid continuously for 6 cycles (req0 reg=3 data=0x11, req1 reg=4 data=0x22) -> grant order 0,1,0,1,0,1; WE=1 every cycle; WriteReg alternates 3,4.
- req1 valid with reg=0, data=0xFFFF_FFFF -> req1_ready=1, following cycle WE=0; a later read of r0 is 0.
- Only req1 valid for 4 cycles, then both valid -> req1 granted 4 times, then req0 granted first (rr_pri=0 after the last req1 grant).
- In RUN, assert clrn=0 mid-transfer, asynchronous to CLK -> WE, WriteReg, WriteData, init_done and both readies go to 0 immediately. After release, the full 31-cycle clear pass repeats.
